// File: rtl/jr_redirect_if.sv
// Handshake bundle between ID-stage decode/forwarding and the JR/JALR redirect unit.
// master = ID stage / PC logic side, slave = jr_redirect_unit.
interface jr_redirect_if #(
   parameter int ADDR_W = 32
);
   logic              stall_in;
   logic              instr_valid;
   logic [5:0]        op_code;
   logic [5:0]        func;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] rs_data;
   logic              rs_ready;
   logic              stall_pc;
   logic              jr_redirect;
   logic [ADDR_W-1:0] jr_target;
   logic              flush_if_id;
   logic              link_we;
   logic [ADDR_W-1:0] link_data;
   logic              misalign_err;
   logic              timeout_err;

   modport master (
      output stall_in, instr_valid, op_code, func, pc_plus4, rs_data, rs_ready,
      input  stall_pc, jr_redirect, jr_target, flush_if_id, link_we, link_data,
             misalign_err, timeout_err
   );

   modport slave (
      input  stall_in, instr_valid, op_code, func, pc_plus4, rs_data, rs_ready,
      output stall_pc, jr_redirect, jr_target, flush_if_id, link_we, link_data,
             misalign_err, timeout_err
   );
endinterface

// File: rtl/jr_redirect_unit.sv
// JR/JALR redirect unit: waits for rs from forwarding, then issues a PC redirect pulse.
// Define JR_DELAY_SLOT_EN for MIPS delay-slot behaviour (no flush, link = pc_plus4 + 4).
module jr_redirect_unit #(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   jr_redirect_if.slave   bus
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_RS  = 2'd1;
   localparam logic [1:0] REDIRECT = 2'd2;

   logic [1:0]        state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] cap_rs;
   logic [ADDR_W-1:0] cap_link;
   logic              cap_jalr;
   logic              timeout_q;

   logic is_jr, is_jalr, hit;
   logic [ADDR_W-1:0] link_val;

   assign is_jr   = (bus.op_code == 6'h00) && (bus.func == 6'h08);
   assign is_jalr = (bus.op_code == 6'h00) && (bus.func == 6'h09);
   assign hit     = bus.instr_valid && (is_jr || is_jalr);

`ifdef JR_DELAY_SLOT_EN
   assign link_val = bus.pc_plus4 + ADDR_W'(4);
`else
   assign link_val = bus.pc_plus4;
`endif

   // Link value and JALR flag are taken at decode; rs may arrive later in WAIT_RS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cap_rs    <= '0;
         cap_link  <= '0;
         cap_jalr  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               if (hit && !bus.stall_in) begin
                  cap_link <= link_val;
                  cap_jalr <= is_jalr;
                  if (bus.rs_ready) begin
                     cap_rs <= bus.rs_data;
                     state  <= REDIRECT;
                  end else begin
                     wait_cnt <= '0;
                     state    <= WAIT_RS;
                  end
               end
            end
            WAIT_RS: begin
               if (bus.rs_ready) begin
                  cap_rs <= bus.rs_data;
                  state  <= REDIRECT;
               end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                  timeout_q <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            REDIRECT: begin
               if (!bus.stall_in) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // All redirect outputs come straight from flops, so they stay stable while stalled.
   assign bus.jr_redirect  = (state == REDIRECT);
   assign bus.jr_target    = {cap_rs[ADDR_W-1:2], 2'b00};
   assign bus.link_we      = (state == REDIRECT) && cap_jalr;
   assign bus.link_data    = cap_link;
   assign bus.misalign_err = (state == REDIRECT) && (cap_rs[1:0] != 2'b00);
   assign bus.timeout_err  = timeout_q;
`ifdef JR_DELAY_SLOT_EN
   assign bus.flush_if_id  = 1'b0;
`else
   assign bus.flush_if_id  = (state == REDIRECT);
`endif

   assign bus.stall_pc = ((state == IDLE) && hit && !bus.rs_ready)
                       || (state == WAIT_RS)
                       || ((state == REDIRECT) && bus.stall_in);
endmodule
